// File: rtl/router_port_rx.sv
// ---------------------------------------------------------------------------
// router_port_rx
//
// Receive side of one serial router input port. A frame (frame_n low) carries
// a 4-bit destination address (LSB first, one bit per cycle), a fixed number
// of pad cycles, then payload bits qualified by valid_n and packed LSB first
// into bytes. Completed bytes are queued in a small FIFO and presented on a
// valid/ready output. The final bit of a packet is the one sampled with
// frame_n high and valid_n low; the byte it completes is tagged out_last.
//
// Parameters
//   FIFO_DEPTH  byte-FIFO entries (power of 2, >= 2)
//   PAD_CYCLES  pad cycles between address and data (>= 1)
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   frame_n    in   serial frame, active-low
//   valid_n    in   serial bit-valid, active-low
//   di         in   serial data bit
//   pkt_start  out  one-cycle pulse after the address is captured
//   pkt_addr   out  [3:0] destination port, held until the next pkt_start
//   out_valid  out  FIFO head valid
//   out_data   out  [7:0] FIFO head byte (0 while empty)
//   out_last   out  FIFO head is the final byte of its packet
//   out_ready  in   consumer accepts the head when out_valid is high
//   err        out  one-cycle error pulse
//   err_code   out  [1:0] 1=abort, 2=partial byte, 3=overflow; held
//   busy       out  high while in ADDR, PAD or DATA
// ---------------------------------------------------------------------------
module router_port_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PAD_CYCLES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_n,
    input  logic       valid_n,
    input  logic       di,
    output logic       pkt_start,
    output logic [3:0] pkt_addr,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int PAD_W = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

    localparam logic [1:0] ERR_ABORT    = 2'd1;
    localparam logic [1:0] ERR_PARTIAL  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    typedef enum logic [2:0] {
        S_DROP,
        S_IDLE,
        S_ADDR,
        S_PAD,
        S_DATA
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [2:0]         addr_sh_q,   addr_sh_d;    // address bits 0..2
    logic [1:0]         addr_cnt_q,  addr_cnt_d;   // next address bit index
    logic [PAD_W-1:0]   pad_cnt_q,   pad_cnt_d;
    logic [6:0]         shift_q,     shift_d;      // first 7 bits of a byte
    logic [2:0]         bit_cnt_q,   bit_cnt_d;
    logic [3:0]         pkt_addr_q,  pkt_addr_d;
    logic               pkt_start_q, pkt_start_d;
    logic               err_q,       err_d;
    logic [1:0]         err_code_q,  err_code_d;

    // FIFO
    logic [8:0]         mem_q [FIFO_DEPTH];        // {last, byte}
    logic [PTR_W-1:0]   wr_ptr_q,    rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               can_push;
    logic [7:0]         push_byte;
    logic               push_last;
    logic [8:0]         head;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign can_push  = !fifo_full || pop;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable is assigned a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_sh_d   = addr_sh_q;
        addr_cnt_d  = addr_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        pkt_addr_d  = pkt_addr_q;
        pkt_start_d = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        push        = 1'b0;
        push_byte   = {di, shift_q};
        push_last   = 1'b0;

        case (state_q)
            S_DROP: begin
                // Discard the remainder of a frame until frame_n rises.
                if (frame_n) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (!frame_n) begin
                    addr_sh_d  = {2'b00, di};
                    addr_cnt_d = 2'd1;
                    state_d    = S_ADDR;
                end
            end

            S_ADDR: begin
                if (frame_n) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                    state_d    = S_IDLE;
                end else begin
                    addr_cnt_d = addr_cnt_q + 2'd1;
                    case (addr_cnt_q)
                        2'd1:    addr_sh_d[1] = di;
                        2'd2:    addr_sh_d[2] = di;
                        default: begin
                            pkt_addr_d  = {di, addr_sh_q};
                            pkt_start_d = 1'b1;
                            pad_cnt_d   = '0;
                            state_d     = S_PAD;
                        end
                    endcase
                end
            end

            S_PAD: begin
                // valid_n carries no meaning during pad and is ignored.
                if (frame_n) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                    state_d    = S_IDLE;
                end else if (pad_cnt_q == PAD_W'(PAD_CYCLES - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    pad_cnt_d = pad_cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (!valid_n) begin
                    shift_d   = {di, shift_q[6:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (frame_n) begin
                        // Final bit of the packet.
                        state_d = S_IDLE;
                        if (bit_cnt_q == 3'd7) begin
                            if (can_push) begin
                                push      = 1'b1;
                                push_last = 1'b1;
                            end else begin
                                err_d      = 1'b1;
                                err_code_d = ERR_OVERFLOW;
                            end
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_PARTIAL;
                        end
                    end else if (bit_cnt_q == 3'd7) begin
                        if (can_push) begin
                            push = 1'b1;
                        end else begin
                            // Rest of the packet is unusable once a byte is lost.
                            err_d      = 1'b1;
                            err_code_d = ERR_OVERFLOW;
                            state_d    = S_DROP;
                        end
                    end
                end else if (frame_n) begin
                    // Frame ended without a final valid bit.
                    err_d      = 1'b1;
                    err_code_d = ERR_PARTIAL;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_DROP;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_DROP;
            addr_sh_q   <= '0;
            addr_cnt_q  <= '0;
            pad_cnt_q   <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            pkt_addr_q  <= '0;
            pkt_start_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_sh_q   <= addr_sh_d;
            addr_cnt_q  <= addr_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            pkt_addr_q  <= pkt_addr_d;
            pkt_start_q <= pkt_start_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // -----------------------------------------------------------------------
    // Byte FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only visible after it
    // has been written, and the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {push_last, push_byte};
        end
    end

    assign head = mem_q[rd_ptr_q];

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? head[7:0] : 8'h00;
    assign out_last  = out_valid ? head[8]   : 1'b0;
    assign pkt_start = pkt_start_q;
    assign pkt_addr  = pkt_addr_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q == S_ADDR) || (state_q == S_PAD) || (state_q == S_DATA);

endmodule
